// File: rtl/arc4_ksa_param.sv
// ARC4 key-scheduling engine with a generic S depth (2^DATA_W) and a
// run-time key length. It fills S with the identity permutation and then
// runs the KSA swap loop, all over an external single-port synchronous
// S memory. Each start request runs both phases back to back.
module arc4_ksa_param #(
  parameter int DATA_W    = 8,
  parameter int KEY_BYTES = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  output logic                               rdy,
  input  logic [8*KEY_BYTES-1:0]             key,
  input  logic [$clog2(KEY_BYTES+1)-1:0]     key_len,
  output logic [DATA_W-1:0]                  mem_addr,
  output logic [DATA_W-1:0]                  mem_wrdata,
  output logic                               mem_wren,
  input  logic [DATA_W-1:0]                  mem_rddata
);

  localparam int LEN_W  = $clog2(KEY_BYTES + 1);
  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  // One state per memory cycle. After CAPJ the value of S[j] lives in
  // mem_wrdata, so no separate sj register is kept.
  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RDI,
    S_CAPI,
    S_RDJ,
    S_CAPJ,
    S_WRI,
    S_WRJ
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   i;
  logic [DATA_W-1:0]   j;
  logic [DATA_W-1:0]   si;
  logic [KIDX_W-1:0]   kidx;
  logic [8*KEY_BYTES-1:0] key_q;
  logic [LEN_W-1:0]    len_q;     // effective key length, always 1..KEY_BYTES

  logic [LEN_W-1:0]    len_eff;
  logic [DATA_W-1:0]   key_byte;
  logic [DATA_W-1:0]   j_next;
  logic                kidx_last;

  // Clamp an out-of-range key length (0 or above KEY_BYTES) to the maximum.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    len_eff = key_len;
    if (key_len == '0 || int'(key_len) > KEY_BYTES)
      len_eff = LEN_W'(KEY_BYTES);
  end

  // Select key byte kidx from the right-aligned key; only constant slices,
  // so this becomes a plain mux. Narrow S widths take the low key bits.
  always_comb begin
    key_byte = '0;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (int'(len_q) - 1 - int'(kidx) == k)
        key_byte = key_q[8*k +: DATA_W];
    end
  end

  // Index arithmetic wraps naturally at DATA_W bits (mod N).
  always_comb begin
    j_next    = j + mem_rddata + key_byte;
    kidx_last = (int'(kidx) == int'(len_q) - 1);
  end

  // Main FSM: all memory-port outputs are registered and set on the edge
  // that enters the cycle in which they are used.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      rdy        <= 1'b1;
      mem_wren   <= 1'b0;
      mem_addr   <= '0;
      mem_wrdata <= '0;
      i          <= '0;
      j          <= '0;
      si         <= '0;
      kidx       <= '0;
      key_q      <= '0;
      len_q      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      case (state)
        S_IDLE: begin
          if (en) begin
            key_q      <= key;
            len_q      <= len_eff;
            i          <= '0;
            rdy        <= 1'b0;
            mem_addr   <= '0;
            mem_wrdata <= '0;
            mem_wren   <= 1'b1;
            state      <= S_INIT;
          end
        end
        S_INIT: begin
          if (i == '1) begin
            i        <= '0;
            j        <= '0;
            kidx     <= '0;
            mem_addr <= '0;
            mem_wren <= 1'b0;
            state    <= S_RDI;
          end else begin
            i          <= i + DATA_W'(1);
            mem_addr   <= i + DATA_W'(1);
            mem_wrdata <= i + DATA_W'(1);
          end
        end
        S_RDI: begin
          state <= S_CAPI;
        end
        S_CAPI: begin
          si       <= mem_rddata;
          j        <= j_next;
          mem_addr <= j_next;
          state    <= S_RDJ;
        end
        S_RDJ: begin
          state <= S_CAPJ;
        end
        S_CAPJ: begin
          mem_addr   <= i;
          mem_wrdata <= mem_rddata;
          mem_wren   <= 1'b1;
          state      <= S_WRI;
        end
        S_WRI: begin
          // When i == j this rewrites S[i] with si, leaving it unchanged.
          mem_addr   <= j;
          mem_wrdata <= si;
          state      <= S_WRJ;
        end
        S_WRJ: begin
          i        <= i + DATA_W'(1);
          kidx     <= kidx_last ? '0 : kidx + KIDX_W'(1);
          mem_wren <= 1'b0;
          if (i == '1) begin
            rdy   <= 1'b1;
            state <= S_IDLE;
          end else begin
            mem_addr <= i + DATA_W'(1);
            state    <= S_RDI;
          end
        end
        default: begin
          state    <= S_IDLE;
          rdy      <= 1'b1;
          mem_wren <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_ksa_param.sv
// Bench for arc4_ksa_param: two instances (DATA_W=8/KEY_BYTES=3 and
// DATA_W=4/KEY_BYTES=2), each with its own synchronous S memory model.
// A golden KSA model queues the expected write stream when a run is
// started; a monitor pops and compares each observed write.
module tb_arc4_ksa_param;

  typedef struct {
    logic [23:0] key;
    int          len;
    int          pa;     // extra en pulse, cycles after start (-1 = none)
    int          pb;
    int          kind;   // 0 normal, 1 reset abort, 2 hold en into next run
  } run_t;

  logic clk;
  int   total;
  int   bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  for (genvar c = 0; c < 2; c++) begin : g_cfg
    localparam int DW = (c == 0) ? 8 : 4;
    localparam int KB = (c == 0) ? 3 : 2;
    localparam int N  = 1 << DW;
    localparam int LW = $clog2(KB + 1);

    logic          rst;
    logic          en;
    logic          rdy;
    logic [8*KB-1:0] key;
    logic [LW-1:0] key_len;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wrdata;
    logic          mem_wren;
    logic [DW-1:0] mem_rddata;
    logic [DW-1:0] mem [N];
    int            exp_q[$];
    int            gold_s [N];
    bit            fin;
    run_t          runs [7];
    int            nrun;

    arc4_ksa_param #(.DATA_W(DW), .KEY_BYTES(KB)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .rdy        (rdy),
      .key        (key),
      .key_len    (key_len),
      .mem_addr   (mem_addr),
      .mem_wrdata (mem_wrdata),
      .mem_wren   (mem_wren),
      .mem_rddata (mem_rddata)
    );

    always @(posedge clk) begin
      if (mem_wren) mem[mem_addr] <= mem_wrdata;
      mem_rddata <= mem[mem_addr];
    end

    always @(negedge clk) begin
      int want;
      if (mem_wren === 1'b1) begin
        if (exp_q.size() == 0) begin
          check($sformatf("dw%0d_extra_wr", DW), int'(mem_addr) * 256 + int'(mem_wrdata), -1);
        end else begin
          want = exp_q.pop_front();
          check($sformatf("dw%0d_wr", DW), int'(mem_addr) * 256 + int'(mem_wrdata), want);
        end
      end
      if (rdy === 1'b1) check($sformatf("dw%0d_idle_wren", DW), mem_wren, 0);
    end

    task automatic load_golden(input logic [23:0] k, input int len);
      int s [N];
      int jj;
      int l;
      int kb;
      int t;
      l = (len == 0 || len > KB) ? KB : len;
      for (int x = 0; x < N; x++) begin
        s[x] = x;
        exp_q.push_back(x * 256 + x);
      end
      jj = 0;
      for (int x = 0; x < N; x++) begin
        kb = int'((k >> (8 * (l - 1 - (x % l)))) & 24'hFF) & (N - 1);
        jj = (jj + s[x] + kb) % N;
        exp_q.push_back(x * 256 + s[jj]);
        exp_q.push_back(jj * 256 + s[x]);
        t = s[x]; s[x] = s[jj]; s[jj] = t;
      end
      gold_s = s;
    endtask

    // Called at a negedge with rdy=1; returns just after the start edge.
    task automatic start_run(input logic [23:0] k, input int len);
      check($sformatf("dw%0d_rdy_pre", DW), rdy, 1);
      key     = k[8*KB-1:0];
      key_len = LW'(len);
      en      = 1'b1;
      load_golden(k, len);
      @(posedge clk);
    endtask

    task automatic finish_run(input int pa, input int pb, input bit hold);
      int n;
      n = 0;
      @(negedge clk);
      en = hold;
      check($sformatf("dw%0d_busy", DW), rdy, 0);
      while (rdy !== 1'b1 && n < 7 * N + 8) begin
        @(negedge clk);
        n++;
        en = (n == pa || n == pb) ? 1'b1 : hold;
      end
      check($sformatf("dw%0d_latency", DW), n, 7 * N);
      check($sformatf("dw%0d_q_empty", DW), exp_q.size(), 0);
      for (int x = 0; x < N; x++)
        check($sformatf("dw%0d_s[%0d]", DW, x), mem[x], gold_s[x]);
    endtask

    task automatic abort_run(input int at);
      @(negedge clk);
      en = 1'b0;
      repeat (at) @(negedge clk);
      check($sformatf("dw%0d_busy_pre_rst", DW), rdy, 0);
      #2 rst = 1'b1;
      #1;
      check($sformatf("dw%0d_rst_rdy", DW), rdy, 1);
      check($sformatf("dw%0d_rst_wren", DW), mem_wren, 0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
    endtask

    initial begin
      fin     = 1'b0;
      rst     = 1'b1;
      en      = 1'b0;
      key     = '0;
      key_len = '0;
      if (c == 0) begin
        nrun    = 7;
        runs[0] = '{24'h00033C, 3, -1, -1, 0};
        runs[1] = '{24'h00033C, 0, -1, -1, 0};
        runs[2] = '{24'h00033C, 3, 10, 500, 0};
        runs[3] = '{24'h00033C, 3, -1, -1, 1};
        runs[4] = '{24'h1A2B3C, 2, -1, -1, 0};
        runs[5] = '{24'hDEADBE, 3, -1, -1, 2};
        runs[6] = '{24'h000102, 2, -1, -1, 0};
      end else begin
        nrun    = 3;
        runs[0] = '{24'h00AA05, 1, -1, -1, 0};
        runs[1] = '{24'h001234, 2, -1, -1, 2};
        runs[2] = '{24'h00F0E1, 3, -1, -1, 0};
      end
      repeat (2) @(negedge clk);
      check($sformatf("dw%0d_reset_rdy", DW), rdy, 1);
      check($sformatf("dw%0d_reset_wren", DW), mem_wren, 0);
      check($sformatf("dw%0d_reset_addr", DW), mem_addr, 0);
      check($sformatf("dw%0d_reset_wrdata", DW), mem_wrdata, 0);
      rst = 1'b0;
      @(negedge clk);
      for (int r = 0; r < nrun; r++) begin
        start_run(runs[r].key, runs[r].len);
        if (runs[r].kind == 1)
          abort_run(300);
        else
          finish_run(runs[r].pa, runs[r].pb, runs[r].kind == 2);
      end
      en  = 1'b0;
      fin = 1'b1;
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    for (int t = 0; t < 60000 && !(g_cfg[0].fin && g_cfg[1].fin); t++)
      @(posedge clk);
    check("all_done", g_cfg[0].fin && g_cfg[1].fin, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
